bolge_hakem: RTL
================

Name: bolge_hakem

Overview:
Round-robin arbiter and sequencer that shares one combinational coordinate-region decoder among N_REQ message sources. It accepts one 16-bit message at a time over valid/ready and decodes its 2-bit region. It returns the region tagged with the source ID over a valid/ready result port. It also keeps saturating per-region hit counters for status readout.

Parameters:
N_REQ, 4, number of requesting sources (2..8)
CNT_W, 16, width of each per-region hit counter
ID_W, $clog2(N_REQ), localparam; source ID width, not overridable

Ports:
clk  input  1  system clock, all logic rising-edge
rst  input  1  synchronous, active-high reset
req_valid  input  N_REQ  per-source message valid
req_mesaj  input  16*N_REQ  per-source message; source i occupies bits [16*i+15:16*i]
req_ready  output  N_REQ  one-hot grant/accept pulse
sonuc_valid  output  1  result valid
sonuc_ready  input  1  result consumer ready
sonuc_bolge  output  2  decoded region
sonuc_id  output  ID_W  index of the source that sent the message
sayac_temizle  input  1  synchronous clear of all hit counters
bolge_sayac  output  4*CNT_W  hit counters; region r occupies bits [CNT_W*r+CNT_W-1:CNT_W*r]

Behaviour:
- Region rule, applied to the latched message m:
  - x = m[11:8] | m[7:4]; y = m[15:12] | m[3:0].
  - y>7 and x>7 -> 2'b11.
  - y>7 and x<=7 -> 2'b00.
  - y<=7 and x>7 -> 2'b10.
  - otherwise -> 2'b01.
- FSM states: BOSTA, HESAP, SONUC.
- BOSTA:
  - If any req_valid bit is set, grant g = first set bit searching from (son_grant+1) mod N_REQ upward with wrap.
  - req_ready[g]=1 combinationally in this cycle only; this is the accept handshake.
  - Latch req_mesaj[g] and g, then go to HESAP.
  - If no req_valid bit is set: req_ready = 0 and stay in BOSTA.
- HESAP:
  - Register the decoded region into sonuc_bolge and g into sonuc_id.
  - Set sonuc_valid=1 on the next edge and go to SONUC.
  - Latency: sonuc_valid rises 2 cycles after the accept cycle.
- SONUC:
  - sonuc_valid=1; sonuc_bolge and sonuc_id are held stable.
  - On sonuc_valid & sonuc_ready: son_grant<=g, increment the counter for sonuc_bolge, clear sonuc_valid, go to BOSTA.
  - Sustained throughput: one message per 3 cycles.
- req_ready is 0 in HESAP and SONUC. A source dropping req_valid while not granted is legal.
- Counters:
  - Unsigned and saturating: a counter at 2^CNT_W-1 stays there.
  - sayac_temizle zeroes all four counters. If it coincides with a result handshake, clear wins and every counter reads 0.
- Reset:
  - State BOSTA; sonuc_valid=0, sonuc_bolge=0, sonuc_id=0, req_ready=0.
  - All counters 0.
  - son_grant=N_REQ-1, so source 0 has first priority.
  - A reset during HESAP or SONUC abandons the in-flight message; sonuc_valid is 0 in the cycle after reset.
- rst dominates sayac_temizle and all handshakes.

Decomposition:
- Shared package holds:
  - state encoding: BOSTA=2'd0, HESAP=2'd1, SONUC=2'd2;
  - region constants: BOLGE_0=2'b00, BOLGE_1=2'b01, BOLGE_2=2'b10, BOLGE_3=2'b11;
  - nibble threshold 4'b0111.
- One sub-module is natural: the existing koordinat_belirleme decoder, instantiated once on the latched message.
- Round-robin pick logic stays inline.

Test Plan:
1. Only req_valid[0], mesaj 16'h8800 at cycle t -> req_ready=4'b0001 at t. At t+2: sonuc_valid=1, sonuc_bolge=2'b11, sonuc_id=0. After the handshake, region-3 counter=1.
2. Single-source messages 16'h0000, 16'h0080, 16'h8000 -> sonuc_bolge 2'b01, 2'b10, 2'b00. Counters for regions 1, 2 and 0 each =1.
3. All four req_valid held high, sonuc_ready=1 -> sonuc_id sequence 0,1,2,3,0. req_ready pulses every 3 cycles.
4. sonuc_ready held low 5 cycles in SONUC -> sonuc_valid, sonuc_bolge and sonuc_id stable throughout; req_ready=0 throughout.
5. CNT_W=2, five 16'h0000 messages -> region-1 counter reads 3 after each of the 4th and 5th handshakes. sayac_temizle asserted in the same cycle as a handshake -> all counters 0.
6. rst asserted in SONUC with req_valid=4'b1111 -> next cycle sonuc_valid=0 and all counters 0. After rst deasserts, the first grant is req_ready=4'b0001.

Source files
------------

// File: rtl/bolge_hakem_pkg.sv
// Shared definitions for the bolge_hakem arbiter/sequencer and its region decoder.
package bolge_hakem_pkg;

  typedef enum logic [1:0] {
    BOSTA = 2'd0,
    HESAP = 2'd1,
    SONUC = 2'd2
  } durum_t;

  localparam logic [1:0] BOLGE_0 = 2'b00;
  localparam logic [1:0] BOLGE_1 = 2'b01;
  localparam logic [1:0] BOLGE_2 = 2'b10;
  localparam logic [1:0] BOLGE_3 = 2'b11;

  // A folded nibble above this value counts as the "high" half of its axis.
  localparam logic [3:0] NIBBLE_ESIK = 4'b0111;

endpackage

// File: rtl/bolge_hakem_koordinat.sv
// Combinational coordinate-region decoder: folds the 16-bit message into an
// x and a y nibble and classifies the point into one of four regions.
module koordinat_belirleme
  import bolge_hakem_pkg::*;
(
  input  logic [15:0] mesaj,
  output logic [1:0]  bolge
);

  logic [3:0] x;
  logic [3:0] y;

  assign x = mesaj[11:8] | mesaj[7:4];
  assign y = mesaj[15:12] | mesaj[3:0];

  // Quadrant selection from the two folded nibbles.
  always_comb begin
    bolge = BOLGE_1;
    if ((y > NIBBLE_ESIK) && (x > NIBBLE_ESIK)) begin
      bolge = BOLGE_3;
    end else if (y > NIBBLE_ESIK) begin
      bolge = BOLGE_0;
    end else if (x > NIBBLE_ESIK) begin
      bolge = BOLGE_2;
    end
  end

endmodule

// File: rtl/bolge_hakem.sv
// Round-robin arbiter that feeds one message at a time from N_REQ sources
// through a shared region decoder, returns the region tagged with the source
// ID, and keeps saturating per-region hit counters.
module bolge_hakem
  import bolge_hakem_pkg::*;
#(
  parameter  int N_REQ = 4,
  parameter  int CNT_W = 16,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [16*N_REQ-1:0]   req_mesaj,
  output logic [N_REQ-1:0]      req_ready,
  output logic                  sonuc_valid,
  input  logic                  sonuc_ready,
  output logic [1:0]            sonuc_bolge,
  output logic [ID_W-1:0]       sonuc_id,
  input  logic                  sayac_temizle,
  output logic [4*CNT_W-1:0]    bolge_sayac
);

  durum_t             durum;
  logic [ID_W-1:0]    son_grant;
  logic               herhangi;
  logic [ID_W-1:0]    secim;
  logic               kabul;
  logic               teslim;

  logic [15:0]        mesaj_p0;
  logic [ID_W-1:0]    grant_p0;
  logic [1:0]         bolge_comb;

  logic [CNT_W-1:0]   sayac [4];

  function automatic logic [CNT_W-1:0] doyur_artir(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Round-robin search starting just after the last served source, with wrap.
  always_comb begin
    int idx;
    idx      = 0;
    herhangi = 1'b0;
    secim    = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(son_grant) + k) % N_REQ;
      if (!herhangi && req_valid[idx]) begin
        herhangi = 1'b1;
        secim    = ID_W'(idx);
      end
    end
  end

  assign kabul  = (durum == BOSTA) && herhangi;
  assign teslim = (durum == SONUC) && sonuc_valid && sonuc_ready;

  // Accept pulse goes only to the chosen source, only while idle.
  always_comb begin
    req_ready = '0;
    if (kabul) begin
      req_ready[secim] = 1'b1;
    end
  end

  // Stage p0: capture the granted message and its source index on accept.
  always_ff @(posedge clk) begin
    if (kabul) begin
      mesaj_p0 <= req_mesaj[16*secim +: 16];
      grant_p0 <= secim;
    end
  end

  koordinat_belirleme u_koordinat (
    .mesaj (mesaj_p0),
    .bolge (bolge_comb)
  );

  // Sequencer: idle/accept, decode into the result registers, hold until taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      durum       <= BOSTA;
      sonuc_valid <= 1'b0;
      sonuc_bolge <= BOLGE_0;
      sonuc_id    <= '0;
      son_grant   <= ID_W'(N_REQ - 1);
    end else begin
      case (durum)
        BOSTA: begin
          if (herhangi) begin
            durum <= HESAP;
          end
        end
        HESAP: begin
          sonuc_bolge <= bolge_comb;
          sonuc_id    <= grant_p0;
          sonuc_valid <= 1'b1;
          durum       <= SONUC;
        end
        SONUC: begin
          if (sonuc_ready) begin
            son_grant   <= sonuc_id;
            sonuc_valid <= 1'b0;
            durum       <= BOSTA;
          end
        end
        default: begin
          durum       <= BOSTA;
          sonuc_valid <= 1'b0;
        end
      endcase
    end
  end

  // Per-region hit counters; a clear request overrides a same-cycle hit.
  always_ff @(posedge clk) begin
    if (rst || sayac_temizle) begin
      for (int r = 0; r < 4; r++) begin
        sayac[r] <= '0;
      end
    end else if (teslim) begin
      sayac[sonuc_bolge] <= doyur_artir(sayac[sonuc_bolge]);
    end
  end

  for (genvar r = 0; r < 4; r++) begin : g_sayac_cikis
    assign bolge_sayac[CNT_W*r +: CNT_W] = sayac[r];
  end

endmodule
